// File: rtl/cpu_pkg.sv
// Purpose : shared definitions for the data-memory side of the CPU (copy engine FSM
//           encoding, word size, default RAM size shared with the data memory).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int WORD_BYTES       = 4;
  localparam int RAM_SIZE_DEFAULT = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } copy_state_t;

  // End address (exclusive) of a byte span, widened to 34 bits so that a base
  // near the top of the 32-bit space plus the span length cannot wrap.
  function automatic logic [33:0] span_end(input logic [31:0] base, input logic [33:0] nbytes);
    return {2'b00, base} + nbytes;
  endfunction

endpackage

// File: rtl/dmem_copy_engine.sv
// Purpose : word-granular block copy master on the data-memory port (read then write per word).
// Latency : start -> done pulse is 2 + 2*len cycles; rejected request -> err pulse 2 cycles.
// Backpressure: none; start is only accepted in IDLE, later starts are dropped, not queued.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, src_addr, dst_addr, len_words   job request (sampled in IDLE)
//   busy, done, err, words_done            job status
//   mem_rd, mem_wr, mem_addr, mem_wdata, mem_rdata   data-memory master port
module dmem_copy_engine
  import cpu_pkg::*;
#(
  parameter int RAM_SIZE = RAM_SIZE_DEFAULT,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  copy_state_t state, state_nxt;

  logic [31:0]      src_cur;
  logic [31:0]      dst_cur;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] words_q;
  logic             err_q;

  // Last driven address/data, so the port holds its value outside READ/WRITE.
  logic [31:0]      addr_hold;
  logic [31:0]      wdata_hold;

  logic [33:0]      len_bytes;
  logic [33:0]      src_end;
  logic [33:0]      dst_end;
  logic             reject;
  logic [LEN_W:0]   words_inc;
  logic             last_word;

  // Bounds check in 34 bits: nothing wraps even for addresses near 2^32.
  assign len_bytes = 34'(len_q) * 34'(WORD_BYTES);
  assign src_end   = span_end(src_cur, len_bytes);
  assign dst_end   = span_end(dst_cur, len_bytes);
  assign reject    = (src_cur[1:0] != 2'b00) || (dst_cur[1:0] != 2'b00) ||
                     (src_end > 34'(RAM_SIZE)) || (dst_end > 34'(RAM_SIZE));

  // One extra bit so the completion compare is exact at the maximum length.
  assign words_inc = {1'b0, words_q} + {{LEN_W{1'b0}}, 1'b1};
  assign last_word = (words_inc == {1'b0, len_q});

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject) begin
          state_nxt = ST_IDLE;
        end else if (len_q == '0) begin
          state_nxt = ST_FIN;
        end else begin
          state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_word ? ST_FIN : ST_READ;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: job parameters, cursors, data buffer, counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_cur    <= '0;
      dst_cur    <= '0;
      data_q     <= '0;
      len_q      <= '0;
      words_q    <= '0;
      err_q      <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      // err is registered so its pulse lands in the cycle after CHECK.
      err_q <= (state == ST_CHECK) && reject;
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_cur <= src_addr;
            dst_cur <= dst_addr;
            len_q   <= len_words;
            words_q <= '0;
          end
        end
        ST_READ: begin
          data_q    <= mem_rdata;
          addr_hold <= src_cur;
        end
        ST_WRITE: begin
          src_cur    <= src_cur + 32'(WORD_BYTES);
          dst_cur    <= dst_cur + 32'(WORD_BYTES);
          words_q    <= words_inc[LEN_W-1:0];
          addr_hold  <= dst_cur;
          wdata_hold <= data_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode. busy covers CHECK/READ/WRITE; it is already low in the
  // cycle carrying the done or err pulse.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    case (state)
      ST_CHECK: busy = 1'b1;
      ST_READ: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = src_cur;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = dst_cur;
        mem_wdata = data_q;
      end
      ST_FIN:  done = 1'b1;
      default: begin
      end
    endcase
  end

  assign err        = err_q;
  assign words_done = words_q;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Purpose : self-checking bench for dmem_copy_engine with a behavioural RAM and copy model.
// Latency : n/a.
// Backpressure: n/a.
module tb_dmem_copy_engine;
  import cpu_pkg::*;

  localparam int LEN_W = 8;
  localparam int RAM   = 256;
  localparam int NW    = RAM / 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             busy;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] words_done;
  logic             mem_rd;
  logic             mem_wr;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  always #5 clk = ~clk;

  dmem_copy_engine #(.RAM_SIZE(RAM), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len_words  (len_words),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_done (words_done),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural data memory: combinational read, write at posedge.
  logic [31:0] tb_mem  [NW];
  logic [31:0] ref_mem [NW];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign mem_rdata = tb_mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (ld_en) tb_mem[ld_idx] <= ld_val;
    else if (mem_wr) tb_mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_wr) wr_cnt <= wr_cnt + 1;
    if (mem_rd) rd_cnt <= rd_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
    if (err)    err_cnt <= err_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] v);
    ld_en  = 1'b1;
    ld_idx = idx[5:0];
    ld_val = v;
    tick();
    ld_en  = 1'b0;
  endtask

  function automatic int mem_diffs();
    int c = 0;
    for (int i = 0; i < NW; i++) if (tb_mem[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  // Reference rule: reject if misaligned or either span ends past RAM.
  function automatic bit model_reject(input logic [31:0] s, input logic [31:0] d, input int n);
    longint sl = {32'h0, s};
    longint dl = {32'h0, d};
    return (s[1:0] != 2'b00) || (d[1:0] != 2'b00) ||
           (sl + 4 * n > RAM) || (dl + 4 * n > RAM);
  endfunction

  // Runs one job and checks outcome, timing, strobe ordering and final memory.
  // If poke is set, a second start with other parameters is pulsed mid-job.
  task automatic run_job(input string nm, input logic [31:0] s, input logic [31:0] d,
                         input int n, input bit e_err, input int e_lat, input int e_wd,
                         input bit poke);
    int cyc, k_rd, k_wr, got_lat, wr0, rd0, dn0, er0;
    bit got_done, got_err, bad;
    for (int i = 0; i < NW; i++) ref_mem[i] = tb_mem[i];
    if (!e_err) for (int i = 0; i < n; i++) ref_mem[int'(d >> 2) + i] = ref_mem[int'(s >> 2) + i];
    wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; er0 = err_cnt;
    check({nm, ":idle_busy"}, busy, 0);
    start = 1'b1; src_addr = s; dst_addr = d; len_words = n[LEN_W-1:0];
    tick();
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; len_words = LEN_W'($urandom);
    cyc = 1; k_rd = 0; k_wr = 0; bad = 0; got_done = 0; got_err = 0; got_lat = -1;
    check({nm, ":busy"}, busy, 1);
    while (cyc < 700 && !got_done && !got_err) begin
      if (mem_rd && mem_wr) bad = 1;
      if (mem_rd) begin
        if (k_rd != k_wr || mem_addr != s + 32'(4 * k_rd)) bad = 1;
        k_rd++;
      end
      if (mem_wr) begin
        if (k_wr + 1 != k_rd || mem_addr != d + 32'(4 * k_wr)) bad = 1;
        k_wr++;
      end
      if (done) begin got_done = 1; got_lat = cyc; end
      if (err)  begin got_err = 1;  got_lat = cyc; end
      if (poke && cyc == 3) begin
        start = 1'b1; src_addr = s ^ 32'h40; dst_addr = d ^ 32'h20; len_words = 2;
      end else begin
        start = 1'b0;
      end
      if (!got_done && !got_err) begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    repeat (3) tick();
    check({nm, ":done"}, got_done, !e_err);
    check({nm, ":err"}, got_err, e_err);
    check({nm, ":latency"}, got_lat, e_lat);
    check({nm, ":words_done"}, words_done, e_wd);
    check({nm, ":strobe_order"}, bad, 0);
    check({nm, ":writes"}, wr_cnt - wr0, e_err ? 0 : n);
    check({nm, ":reads"}, rd_cnt - rd0, e_err ? 0 : n);
    check({nm, ":done_pulses"}, done_cnt - dn0, e_err ? 0 : 1);
    check({nm, ":err_pulses"}, err_cnt - er0, e_err ? 1 : 0);
    check({nm, ":busy_after"}, busy, 0);
    check({nm, ":mem_diffs"}, mem_diffs(), 0);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] s;
    logic [31:0] d;
    int          n;
    bit          e_err;
    int          e_lat;
    int          e_wd;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{"basic",     32'h00,       32'h80, 4,   1'b0, 10, 4};
    tbl[1]  = '{"len0",      32'h10,       32'h20, 0,   1'b0, 2,  0};
    tbl[2]  = '{"src_mis",   32'h02,       32'h80, 1,   1'b1, 2,  0};
    tbl[3]  = '{"dst_oob",   32'h40,       32'hF8, 3,   1'b1, 2,  0};
    tbl[4]  = '{"dst_mis",   32'h00,       32'h81, 1,   1'b1, 2,  0};
    tbl[5]  = '{"exact_fit", 32'h00,       32'h80, 32,  1'b0, 66, 32};
    tbl[6]  = '{"one_over",  32'h00,       32'h84, 32,  1'b1, 2,  0};
    tbl[7]  = '{"src_top",   32'hFC,       32'h40, 1,   1'b0, 4,  1};
    tbl[8]  = '{"wrap",      32'hFFFFFFFC, 32'h00, 1,   1'b1, 2,  0};
    tbl[9]  = '{"max_len",   32'h00,       32'h00, 255, 1'b1, 2,  0};
    tbl[10] = '{"overlap",   32'h00,       32'h04, 3,   1'b0, 8,  3};

    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) tick();
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:err", err, 0);
    check("rst:words_done", words_done, 0);
    check("rst:mem_rd", mem_rd, 0);
    check("rst:mem_wr", mem_wr, 0);
    check("rst:mem_addr", mem_addr, 0);
    check("rst:mem_wdata", mem_wdata, 0);

    for (int i = 0; i < NW; i++) load_word(i, $urandom);
    load_word(0, 32'h11111111);
    load_word(1, 32'h22222222);
    load_word(2, 32'h33333333);
    load_word(3, 32'h44444444);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++)
      run_job(tbl[i].nm, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].e_err, tbl[i].e_lat, tbl[i].e_wd, 1'b0);

    // Forward overlap must propagate word A through the whole range.
    for (int i = 0; i < 4; i++) check($sformatf("overlap_word%0d", i), tb_mem[i], 32'h11111111);

    // A second start while busy is ignored.
    run_job("busy_poke", 32'h20, 32'h90, 4, 1'b0, 10, 4, 1'b1);

    // Reset in the READ cycle after the second WRITE of a len=8 job.
    begin
      int wr0, dn0, er0;
      for (int i = 0; i < NW; i++) ref_mem[i] = tb_mem[i];
      ref_mem[32] = ref_mem[0];
      ref_mem[33] = ref_mem[1];
      wr0 = wr_cnt; dn0 = done_cnt; er0 = err_cnt;
      start = 1'b1; src_addr = 32'h00; dst_addr = 32'h80; len_words = 8;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("rstjob:in_read", mem_rd, 1);
      reset = 1'b1;
      tick();
      check("rstjob:busy", busy, 0);
      check("rstjob:done", done, 0);
      check("rstjob:err", err, 0);
      check("rstjob:words_done", words_done, 0);
      check("rstjob:mem_rd", mem_rd, 0);
      check("rstjob:mem_wr", mem_wr, 0);
      check("rstjob:mem_addr", mem_addr, 0);
      check("rstjob:mem_wdata", mem_wdata, 0);
      reset = 1'b0;
      repeat (4) tick();
      check("rstjob:writes", wr_cnt - wr0, 2);
      check("rstjob:no_done", done_cnt - dn0, 0);
      check("rstjob:no_err", err_cnt - er0, 0);
      check("rstjob:mem_diffs", mem_diffs(), 0);
    end
    run_job("after_reset", 32'h00, 32'h80, 8, 1'b0, 18, 8, 1'b0);

    // Randomised jobs against the reference rules.
    for (int i = 0; i < NW; i++) load_word(i, $urandom);
    for (int j = 0; j < 24; j++) begin
      logic [31:0] s, d;
      int n;
      bit rj;
      s = 32'($urandom_range(0, NW - 1) * 4);
      d = 32'($urandom_range(0, NW - 1) * 4);
      if ($urandom_range(0, 7) == 0) s = s + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d = d + 32'($urandom_range(1, 3));
      n = $urandom_range(0, 20);
      rj = model_reject(s, d, n);
      run_job($sformatf("rand%0d", j), s, d, n, rj, rj ? 2 : 2 + 2 * n, rj ? 0 : n, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
